useq_sequencer_ctrl: RTL
========================

Name: useq_sequencer_ctrl

Overview:
- Control FSM for the microcode address-sequencing datapath.
- Accepts macro-instructions through a valid/ready handshake and decodes the sequencing field of each control word.
- Each cycle it drives the 2-bit next-address mux select, return-stack push/pop and a sequencer enable.
- It tracks call depth, times out wait loops, and reports instruction completion and faults.

Parameters:
- stack_depth, 4: return-stack entries; the call-depth limit.
- WAIT_TIMEOUT, 255: maximum cycles a WAIT may hold before faulting.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- instr_valid  in  1  new macro-instruction available.
- instr_ready  out  1  controller can accept an instruction.
- seq_op  in  3  sequencing field of the current control word.
- cond_sel  in  2  selects which bit of cond_flags is tested.
- cond_flags  in  4  datapath condition flags.
- stall  in  1  datapath stall request.
- stack_empty  in  1  empty flag from the return stack.
- uCode_Addr  out  2  next-address select: 00 incremented, 01 CW branch field, 10 stack return, 11 dispatch.
- stack_push  out  1  push incremented address.
- stack_pop  out  1  pop return address.
- seq_en  out  1  clock-enable for the address registers.
- busy  out  1  instruction in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky fault.
- err_code  out  2  fault cause: 01 overflow, 10 underflow, 11 illegal op or timeout.

Behaviour:
- Reset: state=IDLE, depth=0, wait counter=0. Outputs: uCode_Addr=00, push/pop/seq_en/busy/done/error=0, err_code=00, instr_ready=1.
- Outputs are Mealy: combinational from state and the current-cycle seq_op/cond/stall, so they apply to the control word read in the same cycle.
- IDLE:
  - instr_ready=1, seq_en=0.
  - instr_valid=1 → DISPATCH next cycle.
- DISPATCH (1 cycle):
  - uCode_Addr=11, seq_en=1, busy=1, depth cleared to 0.
  - Select 11 also clears the datapath return stack.
  - → EXEC.
- EXEC, busy=1:
  - stall=1: seq_en=0, push=pop=0, uCode_Addr holds its previous value, state and depth unchanged.
  - stall=0: seq_en=1, and seq_op is decoded as follows.
- seq_op decode in EXEC:
  - 000 NEXT: sel=00.
  - 001 JUMP: sel=01.
  - 010 BRANCH: sel=01 if cond_flags[cond_sel]=1, else 00.
  - 011 CALL: if depth==stack_depth → FAULT, err_code=01, no push. Else push=1, sel=01, depth+1.
  - 100 RET: if depth==0 or stack_empty=1 → FAULT, err_code=10, no pop. Else pop=1, sel=10, depth-1.
  - 101 END: sel=00, done=1 this cycle, → IDLE. instr_ready first rises the following cycle, so back-to-back instructions need a minimum 1-cycle gap.
  - 110 WAIT: while cond_flags[cond_sel]=0, seq_en=0 and the counter increments. Condition true → counter cleared, sel=00, seq_en=1. Counter reaching WAIT_TIMEOUT → FAULT, err_code=11.
  - 111: see Optional Feature.
- FAULT:
  - error=1, seq_en=0, busy=0, instr_ready=0, all strobes 0.
  - Exits only via reset.
- Push and pop are never asserted in the same cycle.
- Reset asserted mid-instruction overrides everything; the next cycle shows reset values.
- stall has priority over FAULT detection: no fault is raised while stall=1.
- depth width is clog2(stack_depth+1) and never wraps.

Optional Feature:
- Macro: USEQ_LOOP_EN.
- Defined:
  - Adds input loop_cnt [7:0] and seq_op 111 = DJNZ.
  - First DJNZ of a loop: internal counter loaded with loop_cnt-1 and sel=01. If loop_cnt=0: sel=00 and no load.
  - Subsequent DJNZ: counter!=0 → decrement, sel=01. Counter==0 → sel=00 and loop-active cleared.
  - Loop state is cleared by DISPATCH and by reset.
- Undefined: seq_op 111 → FAULT with err_code=11; no loop_cnt port.

Test Plan:
- Reset, then instr_valid=1 one cycle → DISPATCH cycle shows uCode_Addr=11, seq_en=1. Then NEXT,NEXT,END → sel 00,00,00; done pulses on the END cycle; instr_ready=1 the cycle after.
- BRANCH with cond_sel=2: cond_flags=0100 → sel=01; cond_flags=0000 → sel=00.
- CALL x4 then CALL (stack_depth=4) → four push pulses with sel=01; fifth CALL gives error=1, err_code=01, no push. Reset clears error.
- DISPATCH then RET → err_code=10, stack_pop=0. CALL,RET → push then pop, sel 01 then 10, depth returns to 0.
- WAIT with flag low for 255 cycles → FAULT, err_code=11. Repeat with flag high at cycle 10 → sel=00, seq_en=1, no fault. Stall held 3 cycles during a CALL → no push until stall drops.
- USEQ_LOOP_EN defined, loop_cnt=3 → DJNZ selects 01,01,01,00 across four passes. Undefined: seq_op 111 → err_code=11.

Source files
------------

// File: rtl/useq_sequencer_ctrl.sv
// useq_sequencer_ctrl: control FSM for the microcode address sequencer (mux select, stack strobes, enable).
// Define USEQ_LOOP_EN to add the loop_cnt input and the DJNZ loop op on seq_op 111.
module useq_sequencer_ctrl #(
    parameter int stack_depth  = 4,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] seq_op,
    input  logic [1:0] cond_sel,
    input  logic [3:0] cond_flags,
    input  logic       stall,
    input  logic       stack_empty,
`ifdef USEQ_LOOP_EN
    input  logic [7:0] loop_cnt,
`endif
    output logic [1:0] uCode_Addr,
    output logic       stack_push,
    output logic       stack_pop,
    output logic       seq_en,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    localparam int DEPTH_W = $clog2(stack_depth + 1);
    localparam int WCNT_W  = $clog2(WAIT_TIMEOUT + 1);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(stack_depth);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
    localparam logic [WCNT_W-1:0]  WAIT_LAST = WCNT_W'(WAIT_TIMEOUT - 1);
    localparam logic [WCNT_W-1:0]  WCNT_ONE  = WCNT_W'(1);

    localparam logic [2:0] OP_NEXT   = 3'b000;
    localparam logic [2:0] OP_JUMP   = 3'b001;
    localparam logic [2:0] OP_BRANCH = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;
    localparam logic [2:0] OP_END    = 3'b101;
    localparam logic [2:0] OP_WAIT   = 3'b110;

    localparam logic [1:0] SEL_INC  = 2'b00;
    localparam logic [1:0] SEL_BR   = 2'b01;
    localparam logic [1:0] SEL_RET  = 2'b10;
    localparam logic [1:0] SEL_DISP = 2'b11;

    localparam logic [1:0] ERR_OVF = 2'b01;
    localparam logic [1:0] ERR_UNF = 2'b10;
    localparam logic [1:0] ERR_ILL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_EXEC,
        S_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [1:0]          err_q, err_d;
    logic [1:0]          sel_q;
    logic                cond;
`ifdef USEQ_LOOP_EN
    logic                loop_act_q, loop_act_d;
    logic [7:0]          loop_q, loop_d;
`endif

    assign cond = cond_flags[cond_sel];

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        wcnt_d      = wcnt_q;
        err_d       = err_q;
`ifdef USEQ_LOOP_EN
        loop_act_d  = loop_act_q;
        loop_d      = loop_q;
`endif
        uCode_Addr  = SEL_INC;
        stack_push  = 1'b0;
        stack_pop   = 1'b0;
        seq_en      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        instr_ready = 1'b0;
        error       = (state_q == S_FAULT);
        err_code    = err_q;

        unique case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = S_DISPATCH;
            end
            S_DISPATCH: begin
                uCode_Addr = SEL_DISP;
                seq_en     = 1'b1;
                busy       = 1'b1;
                depth_d    = '0;
                wcnt_d     = '0;
`ifdef USEQ_LOOP_EN
                loop_act_d = 1'b0;
                loop_d     = '0;
`endif
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                busy = 1'b1;
                if (stall) begin
                    // Address mux keeps presenting the last select while frozen.
                    uCode_Addr = sel_q;
                end else begin
                    seq_en = 1'b1;
                    case (seq_op)
                        OP_NEXT:   uCode_Addr = SEL_INC;
                        OP_JUMP:   uCode_Addr = SEL_BR;
                        OP_BRANCH: uCode_Addr = cond ? SEL_BR : SEL_INC;
                        OP_CALL: begin
                            if (depth_q == DEPTH_MAX) begin
                                seq_en  = 1'b0;
                                err_d   = ERR_OVF;
                                state_d = S_FAULT;
                            end else begin
                                stack_push = 1'b1;
                                uCode_Addr = SEL_BR;
                                depth_d    = depth_q + DEPTH_ONE;
                            end
                        end
                        OP_RET: begin
                            if (depth_q == '0 || stack_empty) begin
                                seq_en  = 1'b0;
                                err_d   = ERR_UNF;
                                state_d = S_FAULT;
                            end else begin
                                stack_pop  = 1'b1;
                                uCode_Addr = SEL_RET;
                                depth_d    = depth_q - DEPTH_ONE;
                            end
                        end
                        OP_END: begin
                            done    = 1'b1;
                            state_d = S_IDLE;
                        end
                        OP_WAIT: begin
                            if (cond) begin
                                wcnt_d = '0;
                            end else begin
                                seq_en = 1'b0;
                                // wcnt_q counts earlier held cycles; this one is the last allowed.
                                if (wcnt_q == WAIT_LAST) begin
                                    err_d   = ERR_ILL;
                                    state_d = S_FAULT;
                                end else begin
                                    wcnt_d = wcnt_q + WCNT_ONE;
                                end
                            end
                        end
                        default: begin
`ifdef USEQ_LOOP_EN
                            if (!loop_act_q) begin
                                if (loop_cnt != 8'd0) begin
                                    loop_act_d = 1'b1;
                                    loop_d     = loop_cnt - 8'd1;
                                    uCode_Addr = SEL_BR;
                                end
                            end else if (loop_q != 8'd0) begin
                                loop_d     = loop_q - 8'd1;
                                uCode_Addr = SEL_BR;
                            end else begin
                                loop_act_d = 1'b0;
                            end
`else
                            seq_en  = 1'b0;
                            err_d   = ERR_ILL;
                            state_d = S_FAULT;
`endif
                        end
                    endcase
                end
            end
            S_FAULT: begin
                // Sticky: everything stays quiet until reset.
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            depth_q    <= '0;
            wcnt_q     <= '0;
            err_q      <= 2'b00;
            sel_q      <= SEL_INC;
`ifdef USEQ_LOOP_EN
            loop_act_q <= 1'b0;
            loop_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            wcnt_q     <= wcnt_d;
            err_q      <= err_d;
            sel_q      <= uCode_Addr;
`ifdef USEQ_LOOP_EN
            loop_act_q <= loop_act_d;
            loop_q     <= loop_d;
`endif
        end
    end

endmodule
